// File: rtl/irq_pending_dispatch.sv
// Sticky 4-source interrupt pending register with mask, fixed priority (bit 3 highest)
// and a valid/ready offer; a source stays in service until the consumer pulses eoi.
module irq_pending_dispatch #(
    parameter bit EDGE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] mask,
    input  logic       out_ready,
    input  logic       eoi,
    output logic       out_valid,
    output logic [1:0] out_id,
    output logic [3:0] pending,
    output logic       busy,
    output logic [1:0] in_service,
    output logic [3:0] overflow
);

    localparam int unsigned NSRC = 4;
    localparam int unsigned IDW  = 2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] OFFER = 2'd1;
    localparam logic [1:0] BUSY  = 2'd2;

    logic [1:0]      state;
    logic [1:0]      state_nx;
    logic [NSRC-1:0] req_q;
    logic [NSRC-1:0] set;
    logic [NSRC-1:0] clr;
    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] pending_nx;
    logic [NSRC-1:0] overflow_nx;
    logic [IDW-1:0]  out_id_nx;
    logic [IDW-1:0]  in_service_nx;
    logic            accept;

    // Later (higher) indices overwrite earlier ones, so the highest set bit wins.
    function automatic logic [IDW-1:0] highest(input logic [NSRC-1:0] v);
        logic [IDW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (v[i]) idx = IDW'(i);
        end
        return idx;
    endfunction

    assign set         = EDGE ? (req & ~req_q) : req;
    assign clr         = accept ? (NSRC'(1) << out_id) : '0;
    assign eligible    = pending & ~mask;
    assign pending_nx  = set | (pending & ~clr);
    assign overflow_nx = EDGE ? (set & pending & ~clr) : '0;

    // Next-state and latched offer/service bookkeeping.
    always_comb begin
        state_nx      = state;
        out_id_nx     = out_id;
        in_service_nx = in_service;
        accept        = 1'b0;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    state_nx  = OFFER;
                    out_id_nx = highest(eligible);
                end
            end
            OFFER: begin
                if (out_ready) begin
                    accept        = 1'b1;
                    in_service_nx = out_id;
                    state_nx      = BUSY;
                end
            end
            BUSY: begin
                if (eoi) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_q      <= '0;
            pending    <= '0;
            overflow   <= '0;
            out_valid  <= 1'b0;
            out_id     <= '0;
            busy       <= 1'b0;
            in_service <= '0;
        end else begin
            state      <= state_nx;
            req_q      <= req;
            pending    <= pending_nx;
            overflow   <= overflow_nx;
            out_valid  <= (state_nx == OFFER);
            out_id     <= out_id_nx;
            busy       <= (state_nx == BUSY);
            in_service <= in_service_nx;
        end
    end

endmodule

// File: tb/tb_irq_pending_dispatch.sv
// Randomized bench for irq_pending_dispatch (EDGE=1) with a behavioural model and an offer scoreboard.
module tb_irq_pending_dispatch;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'h0;
    logic [3:0] mask = 4'h0;
    logic       out_ready = 1'b0;
    logic       eoi = 1'b0;
    logic       out_valid;
    logic [1:0] out_id;
    logic [3:0] pending;
    logic       busy;
    logic [1:0] in_service;
    logic [3:0] overflow;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    // Behavioural model: offer = -1 when nothing offered, svc = -1 when nothing in service.
    logic [3:0] m_pend  = 4'h0;
    logic [3:0] m_reqq  = 4'h0;
    logic [3:0] m_ovf   = 4'h0;
    logic [1:0] m_outid = 2'd0;
    logic [1:0] m_insvc = 2'd0;
    int         m_offer = -1;
    int         m_svc   = -1;
    logic       prev_v  = 1'b0;

    irq_pending_dispatch #(.EDGE(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .mask       (mask),
        .out_ready  (out_ready),
        .eoi        (eoi),
        .out_valid  (out_valid),
        .out_id     (out_id),
        .pending    (pending),
        .busy       (busy),
        .in_service (in_service),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin : model
        logic [3:0] ev;
        logic [3:0] clr;
        logic [3:0] elig;
        bit         acc;
        if (rst) begin
            m_pend  = 4'h0;
            m_reqq  = 4'h0;
            m_ovf   = 4'h0;
            m_outid = 2'd0;
            m_insvc = 2'd0;
            m_offer = -1;
            m_svc   = -1;
            exp_q.delete();
        end else begin
            ev    = req & ~m_reqq;
            acc   = (m_offer >= 0) && out_ready;
            clr   = acc ? (4'h1 << m_offer) : 4'h0;
            m_ovf = ev & m_pend & ~clr;
            if (m_offer >= 0) begin
                if (acc) begin
                    m_svc   = m_offer;
                    m_insvc = 2'(m_offer);
                    m_offer = -1;
                end
            end else if (m_svc >= 0) begin
                if (eoi) m_svc = -1;
            end else begin
                elig = m_pend & ~mask;
                for (int i = 3; i >= 0; i--) begin
                    if (elig[i] && m_offer < 0) m_offer = i;
                end
                if (m_offer >= 0) begin
                    m_outid = 2'(m_offer);
                    exp_q.push_back(m_offer);
                end
            end
            m_pend = ev | (m_pend & ~clr);
            m_reqq = req;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    // Per-cycle state checks plus scoreboard pop on every new offer.
    always @(negedge clk) begin
        check("pending", 32'(pending), 32'(m_pend));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("out_valid", 32'(out_valid), 32'(m_offer >= 0));
        check("busy", 32'(busy), 32'(m_svc >= 0));
        check("out_id", 32'(out_id), 32'(m_outid));
        check("in_service", 32'(in_service), 32'(m_insvc));
        if (out_valid === 1'b1 && prev_v !== 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL offer_pop at %0t: got offer id %0d expected no offer", $time, out_id);
            end else begin
                check("offer_id", 32'(out_id), 32'(exp_q.pop_front()));
            end
        end
        prev_v = out_valid;
    end

    task automatic step(input logic [3:0] r, input logic [3:0] mk, input logic rd,
                        input logic e, input logic rs);
        @(negedge clk);
        req       = r;
        mask      = mk;
        out_ready = rd;
        eoi       = e;
        rst       = rs;
    endtask

    task automatic drain();
        for (int i = 0; i < 10; i++) step(4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        logic [3:0] r;
        logic [3:0] mk;
        step(4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        step(4'h0, 4'h0, 1'b0, 1'b0, 1'b1);

        // Single request, then accept and eoi.
        step(4'b0001, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        step(4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        step(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        step(4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        step(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

        // Two simultaneous sources, back-to-back accept/eoi.
        step(4'b0110, 4'h0, 1'b1, 1'b1, 1'b0);
        drain();

        // Higher-priority arrival while an offer is held.
        step(4'b0010, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        step(4'b1000, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        drain();

        // Masked source held pending until the mask drops.
        step(4'b1000, 4'b1000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(4'h0, 4'b1000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        drain();

        // Overflow on re-edge while pending, then a re-edge in the accept cycle.
        step(4'b0100, 4'h0, 1'b0, 1'b0, 1'b0);
        step(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        step(4'b0100, 4'h0, 1'b0, 1'b0, 1'b0);
        step(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        drain();
        step(4'b0100, 4'h0, 1'b0, 1'b0, 1'b0);
        step(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        step(4'b0100, 4'h0, 1'b1, 1'b0, 1'b0);
        step(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        drain();

        // Reset during OFFER with a request held through reset, then during BUSY.
        step(4'b0001, 4'h0, 1'b0, 1'b0, 1'b0);
        step(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        step(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        step(4'b0010, 4'h0, 1'b0, 1'b0, 1'b1);
        step(4'b0010, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b0010, 4'h0, 1'b0, 1'b0, 1'b0);
        step(4'b0010, 4'h0, 1'b1, 1'b0, 1'b0);
        step(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        step(4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        step(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        drain();

        // Randomized traffic.
        mk = 4'h0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            if ($urandom_range(0, 19) == 0) mk = 4'($urandom_range(0, 15));
            step(r, mk, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 199) == 0));
        end
        drain();
        step(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
